// File: rtl/serial_det_scheduler.sv
// serial_det_scheduler
//
// Round-robin arbiter that lends one serial sequence detector to N_CH
// bit-serial requesters. For each grant it clears the detector for one cycle,
// streams FRAME_LEN bits of the granted channel into it, counts detector hits
// (saturating), and reports the count with a one-cycle done pulse.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req        per-channel request
//   ch_bit     per-channel serial data, one bit consumed per RUN cycle
//   det_w      detector hit (Mealy, same cycle as det_j)
//   det_j      serial bit to detector (0 outside RUN)
//   det_clr    one-cycle synchronous detector clear (CLEAR state)
//   gnt        one-hot grant, high in CLEAR and RUN
//   busy       high in CLEAR, RUN and REPORT
//   done       one-cycle pulse in REPORT
//   done_ch    channel of the last completed frame (held)
//   hit_cnt    hits of the last completed frame (held, saturating)
//   dbg_state  current FSM state (0 IDLE, 1 CLEAR, 2 RUN, 3 REPORT)
//
// Handshake: a channel raises req and keeps it high; gnt answers one cycle
// after req is sampled in IDLE. req[sel] must stay high through CLEAR and RUN;
// if it is low at any edge there, the frame is abandoned silently (no done,
// hit_cnt/done_ch untouched) and the round-robin pointer still advances.

module serial_det_scheduler #(
    parameter int N_CH      = 4,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 4,
    localparam int IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic [N_CH-1:0]  ch_bit,
    input  logic             det_w,
    output logic             det_j,
    output logic             det_clr,
    output logic [N_CH-1:0]  gnt,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] done_ch,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_RUN    = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    localparam int             BC_W    = 8;
    localparam logic [CNT_W-1:0] HIT_MAX = '1;

    state_t           state, state_d;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] ptr;
    logic [BC_W-1:0]  bit_cnt;
    logic [CNT_W-1:0] hits;
    logic [CNT_W-1:0] hits_next;
    logic [IDX_W-1:0] rr_pick;
    logic [IDX_W-1:0] rr_cand;
    logic             rr_found;
    logic             last_bit;

    assign dbg_state = state;
    assign last_bit  = (bit_cnt == BC_W'(FRAME_LEN - 1));
    // Hit counter sticks at all-ones instead of wrapping.
    assign hits_next = (det_w && (hits != HIT_MAX)) ? hits + 1'b1 : hits;

    // Round-robin search: first requester strictly after ptr, wrapping.
    always_comb begin
        rr_pick  = '0;
        rr_cand  = '0;
        rr_found = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            rr_cand = IDX_W'((int'(ptr) + i) % N_CH);
            if (!rr_found && req[rr_cand]) begin
                rr_pick  = rr_cand;
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        gnt     = '0;
        det_clr = 1'b0;
        det_j   = 1'b0;
        done    = 1'b0;
        busy    = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (|req) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                gnt[sel] = 1'b1;
                det_clr  = 1'b1;
                state_d  = req[sel] ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                gnt[sel] = 1'b1;
                det_j    = ch_bit[sel];
                if (!req[sel])    state_d = S_IDLE;
                else if (last_bit) state_d = S_REPORT;
            end
            S_REPORT: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame datapath: selection, pointer, counters and held report values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel     <= '0;
            ptr     <= IDX_W'(N_CH - 1);
            bit_cnt <= '0;
            hits    <= '0;
            hit_cnt <= '0;
            done_ch <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) sel <= rr_pick;
                end
                S_CLEAR: begin
                    bit_cnt <= '0;
                    hits    <= '0;
                    if (!req[sel]) ptr <= sel;
                end
                S_RUN: begin
                    if (!req[sel]) begin
                        ptr <= sel;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        hits    <= hits_next;
                        // Load the report on the last bit so a hit on that
                        // bit is included and REPORT already shows it.
                        if (last_bit) begin
                            hit_cnt <= hits_next;
                            done_ch <= sel;
                        end
                    end
                end
                S_REPORT: begin
                    ptr <= sel;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_det_scheduler.sv
module tb_serial_det_scheduler;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (N_CH=4, FRAME_LEN=8, CNT_W=4) ----------------
  logic [3:0] req = '0;
  logic [3:0] ch_bit = '0;
  logic       det_w, det_j, det_clr, busy, done;
  logic [3:0] gnt;
  logic [1:0] done_ch;
  logic [3:0] hit_cnt;
  logic [1:0] dbg_state;
  logic       w_force = 1'b0;

  serial_det_scheduler #(.N_CH(4), .FRAME_LEN(8), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .req(req), .ch_bit(ch_bit), .det_w(det_w),
    .det_j(det_j), .det_clr(det_clr), .gnt(gnt), .busy(busy), .done(done),
    .done_ch(done_ch), .hit_cnt(hit_cnt), .dbg_state(dbg_state)
  );

  // Behavioural Mealy detector for overlapping "1101", cleared by det_clr.
  logic [2:0] h = '0;
  assign det_w = ((h == 3'b110) & det_j) | w_force;
  always @(posedge clk) begin
    if (det_clr) h <= '0;
    else         h <= {h[1:0], det_j};
  end

  // ---------------- saturation DUT (FRAME_LEN=16, CNT_W=2) ----------------
  logic [3:0] req_s = '0;
  logic [3:0] ch_bit_s = '0;
  logic       det_w_s, det_j_s, det_clr_s, busy_s, done_s;
  logic [3:0] gnt_s;
  logic [1:0] done_ch_s;
  logic [1:0] hit_cnt_s;
  logic [1:0] dbg_state_s;

  serial_det_scheduler #(.N_CH(4), .FRAME_LEN(16), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .req(req_s), .ch_bit(ch_bit_s), .det_w(det_w_s),
    .det_j(det_j_s), .det_clr(det_clr_s), .gnt(gnt_s), .busy(busy_s), .done(done_s),
    .done_ch(done_ch_s), .hit_cnt(hit_cnt_s), .dbg_state(dbg_state_s)
  );

  logic [2:0] h_s = '0;
  assign det_w_s = (h_s == 3'b110) & det_j_s;
  always @(posedge clk) begin
    if (det_clr_s) h_s <= '0;
    else           h_s <= {h_s[1:0], det_j_s};
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Returns 2 time units after a rising edge; inputs change and outputs are
  // sampled there, well clear of the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    req = '0;
    req_s = '0;
    w_force = 1'b0;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  // Called with req already set and the DUT in IDLE; seq is written in
  // stream order (leftmost bit goes first).
  task automatic do_frame(input int ch, input logic [7:0] seq, input int exp_hits,
                          input bit force_after, output int start_cyc);
    logic [7:0] exp_v;
    exp_q.push_back(8'(exp_hits));
    tick();
    start_cyc = cyc;
    chk("clr_gnt", gnt, 32'(1) << ch);
    chk("clr_pulse", det_clr, 1);
    chk("clr_j", det_j, 0);
    chk("clr_state", dbg_state, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      ch_bit[ch] = seq[7-i];
      #1;
      chk("run_gnt", gnt, 32'(1) << ch);
      chk("run_j", det_j, seq[7-i]);
      chk("run_clr", det_clr, 0);
    end
    tick();
    if (force_after) w_force = 1'b1;
    exp_v = exp_q.pop_front();
    chk("rep_done", done, 1);
    chk("rep_ch", done_ch, ch);
    chk("rep_hits", hit_cnt, exp_v);
    chk("rep_gnt", gnt, 0);
    chk("rep_busy", busy, 1);
    chk("rep_j", det_j, 0);
    tick();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_hits", hit_cnt, exp_v);
    w_force = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  int s0, s1, s2, s3;

  initial begin
    #1;
    apply_reset();

    // Reset state
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hits", hit_cnt, 0);
    chk("rst_done_ch", done_ch, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_sat_hits", hit_cnt_s, 0);

    // Single frame on ch0: 1,1,0,1,1,0,1,0 -> two overlapping hits
    req = 4'b0001;
    do_frame(0, 8'b11011010, 2, 1'b0, s0);

    // Abort: ch2 granted next (pointer at 0), req[2] drops after 4 bits
    req = 4'b1101;
    tick();
    chk("ab_clr_gnt", gnt, 4'b0100);
    for (int i = 0; i < 4; i++) begin
      tick();
      ch_bit[2] = (i == 2) ? 1'b0 : 1'b1;
    end
    tick();
    req = 4'b1001;
    #1;
    chk("ab_run_gnt", gnt, 4'b0100);
    tick();
    chk("ab_gnt", gnt, 0);
    chk("ab_done", done, 0);
    chk("ab_busy", busy, 0);
    chk("ab_hits_held", hit_cnt, 2);
    chk("ab_ch_held", done_ch, 0);
    // Next requester after 2 is 3
    do_frame(3, 8'b00000000, 0, 1'b0, s0);
    req = 4'b0000;
    tick();

    // Round-robin with req=1011 held: 0,1,3,0, 11 cycles start-to-start
    apply_reset();
    req = 4'b1011;
    do_frame(0, 8'b11111111, 0, 1'b0, s0);
    do_frame(1, 8'b11010000, 1, 1'b0, s1);
    do_frame(3, 8'b01101101, 2, 1'b0, s2);
    do_frame(0, 8'b00000000, 0, 1'b0, s3);
    chk("rr_space01", s1 - s0, 11);
    chk("rr_space13", s2 - s1, 11);
    chk("rr_space30", s3 - s2, 11);
    req = 4'b0000;
    tick();

    // Saturation on the CNT_W=2, FRAME_LEN=16 instance: five hits -> 3
    begin
      logic [15:0] sseq;
      sseq = 16'b1101101101101101;
      req_s = 4'b0001;
      tick();
      chk("sat_clr_gnt", gnt_s, 4'b0001);
      for (int i = 0; i < 16; i++) begin
        tick();
        ch_bit_s[0] = sseq[15-i];
      end
      tick();
      chk("sat_done", done_s, 1);
      chk("sat_hits", hit_cnt_s, 3);
      chk("sat_ch", done_ch_s, 0);
      req_s = 4'b0000;
      tick();
      chk("sat_idle_done", done_s, 0);
    end

    // Async reset mid-RUN
    apply_reset();
    req = 4'b0010;
    do_frame(1, 8'b11010000, 1, 1'b0, s0);
    tick();
    chk("ar_clr_gnt", gnt, 4'b0010);
    tick();
    ch_bit[1] = 1'b1;
    #1;
    chk("ar_run_j", det_j, 1);
    chk("ar_pre_hits", hit_cnt, 1);
    chk("ar_pre_ch", done_ch, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_gnt", gnt, 0);
    chk("ar_clr", det_clr, 0);
    chk("ar_j", det_j, 0);
    chk("ar_done", done, 0);
    chk("ar_busy", busy, 0);
    chk("ar_hits", hit_cnt, 0);
    chk("ar_ch", done_ch, 0);
    chk("ar_state", dbg_state, 0);
    tick();
    rst = 1'b1;
    req = 4'b1111;
    tick();
    chk("ar_first_gnt", gnt, 4'b0001);
    req = 4'b0000;
    tick();
    chk("ar_abort_idle", gnt, 0);

    // Hit on the last RUN bit counts; det_w in REPORT/IDLE does not
    apply_reset();
    req = 4'b0001;
    do_frame(0, 8'b00001101, 1, 1'b1, s0);
    req = 4'b0000;
    w_force = 1'b1;
    tick();
    chk("lb_hits_after_idle_w", hit_cnt, 1);
    chk("lb_busy", busy, 0);
    w_force = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
